// File: rtl/pio_in_pkg.sv
// Shared constants and bus payload type for the edge-capture input PIO.
// Register word addresses, data bus width, minimum synchroniser depth.
// Optional feature macro used by this slice: PIO_IN_DEBOUNCE_EN.
package pio_in_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned SYNC_MIN = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CAP  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL = 3'd4;

    // One slave bus cycle as seen by the register block.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/pio_in_bit_filter.sv
// Per-bit input conditioning: SYNC_STAGES-flop synchroniser and, when
// PIO_IN_DEBOUNCE_EN is defined, a stability counter that only lets a
// change through after DEBOUNCE_CYCLES consecutive cycles.
// Ports: clk, reset (sync, active-high), din (async pin), filt (conditioned bit).
module pio_in_bit_filter
    import pio_in_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_MIN
`ifdef PIO_IN_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;

    // Synchroniser shift chain; last stage is the metastability-safe value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt_r;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            filt_r <= 1'b0;
        end else if (sync_q == filt_r) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_r <= sync_q;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign filt = filt_r;
`else
    assign filt = sync_q;
`endif

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO with per-bit rising/falling edge capture,
// write-1-to-clear capture register and masked level interrupt.
// Ports: clk, reset (sync, active-high), address/chipselect/write_n/
// writedata/readdata (slave bus, 1-cycle read latency), in_port (async
// pins), irq (level, active-high).
// Optional debounce filter enabled by defining PIO_IN_DEBOUNCE_EN.
module pio_in_edge_capture
    import pio_in_pkg::*;
#(
    parameter int unsigned     WIDTH           = 8,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RISE_RESET     = '1,
    parameter logic [WIDTH-1:0] FALL_RESET     = '1,
    parameter int unsigned     DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    // Elaboration-time parameter sanity.
    if (WIDTH < 1 || WIDTH > DATA_W) begin : g_bad_width
        $error("pio_in_edge_capture: WIDTH out of range");
    end
    if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
        $error("pio_in_edge_capture: SYNC_STAGES too small");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("pio_in_edge_capture: DEBOUNCE_CYCLES must be >= 1");
    end

    bus_req_t          req_c;
    logic [WIDTH-1:0]  filt;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  rise_en;
    logic [WIDTH-1:0]  fall_en;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  cap;
    logic [WIDTH-1:0]  ev_c;
    logic [WIDTH-1:0]  clr_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic              unused_bits_c;

    assign req_c.addr  = address;
    assign req_c.we    = chipselect & ~write_n;
    assign req_c.wdata = writedata;

    // Write data above WIDTH is intentionally dropped.
    assign unused_bits_c = ^req_c.wdata;

    // Per-bit synchroniser / optional debounce.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_bit_filter #(
            .SYNC_STAGES     (SYNC_STAGES)
`ifdef PIO_IN_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
        ) u_filter (
            .clk   (clk),
            .reset (reset),
            .din   (in_port[i]),
            .filt  (filt[i])
        );
    end

    assign ev_c  = (filt & ~prev & rise_en) | (~filt & prev & fall_en);
    assign clr_c = (req_c.we && (req_c.addr == ADDR_CAP)) ? req_c.wdata[WIDTH-1:0] : '0;

    // Read mux over current (pre-write) register values.
    always_comb begin
        rd_mux_c = '0;
        case (req_c.addr)
            ADDR_DATA: rd_mux_c = DATA_W'(filt);
            ADDR_RISE: rd_mux_c = DATA_W'(rise_en);
            ADDR_MASK: rd_mux_c = DATA_W'(mask);
            ADDR_CAP:  rd_mux_c = DATA_W'(cap);
            ADDR_FALL: rd_mux_c = DATA_W'(fall_en);
            default:   rd_mux_c = '0;
        endcase
    end

    // Register block; a new event on a bit outranks a clear of that bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            rise_en  <= RISE_RESET;
            fall_en  <= FALL_RESET;
            mask     <= '0;
            cap      <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            prev <= filt;
            if (req_c.we) begin
                case (req_c.addr)
                    ADDR_RISE: rise_en <= req_c.wdata[WIDTH-1:0];
                    ADDR_MASK: mask    <= req_c.wdata[WIDTH-1:0];
                    ADDR_FALL: fall_en <= req_c.wdata[WIDTH-1:0];
                    default:   ;
                endcase
            end
            cap      <= (cap & ~clr_c) | ev_c;
            readdata <= rd_mux_c;
            irq      <= |(cap & mask);
        end
    end

endmodule

// File: doc/pio_in_edge_capture.md
Name: pio_in_edge_capture

Overview:
- Parametrised Avalon-MM input PIO: successor to the 1-bit edge-capture input port used for CPU reset/status lines.
- Generalised to WIDTH channels, with configurable synchroniser depth, per-bit rising/falling edge enables, write-1-to-clear capture, and a level IRQ to the CPU.
- Sits on the system interconnect as a slave; in_port comes from asynchronous board pins.

Parameters:
- WIDTH, 8, number of input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (min 2).
- RISE_RESET, all-ones, reset value of edge_rise_en register.
- FALL_RESET, all-ones, reset value of edge_fall_en register.
- DEBOUNCE_CYCLES, 16, stable cycles required before a filtered change (used only with PIO_IN_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous input pins.
- irq  out  1  interrupt request, level, active-high.

Behaviour:
- Interface: one clock clk. Reset is synchronous and active-high on port reset, sampled on posedge clk only.
- Reset values: readdata=0, irq=0, sync chain=0, prev=0, edge_capture=0, irq_mask=0, edge_rise_en=RISE_RESET, edge_fall_en=FALL_RESET.
- Reset mid-operation: all of the above restored on the next edge; pending captures are lost.
- Synchroniser: in_port passes through SYNC_STAGES flops per bit; the last stage gives sync_q.
- Filtered value filt = sync_q (or the debounced value, see Optional Feature). prev <= filt every cycle.
- Edge detect: rise = filt & ~prev & edge_rise_en; fall = ~filt & prev & edge_fall_en; ev = rise | fall.
- Minimum pin-to-capture latency: SYNC_STAGES+1 cycles.
- Register map (word address):
  - 0 data: R = filt; writes ignored.
  - 1 edge_rise_en: R/W.
  - 2 irq_mask: R/W.
  - 3 edge_capture: R; write-1-to-clear per bit.
  - 4 edge_fall_en: R/W.
  - 5-7: read 0, writes ignored.
- Write occurs when chipselect & ~write_n.
- Capture update per bit: next = (cap & ~clr) | ev, where clr = writedata bits on a write to address 3. A simultaneous clear and new event on the same bit leaves the bit SET; the event wins.
- Reads: readdata <= mux(address) every cycle, independent of chipselect; 1-cycle latency. A read returns the pre-update value of registers written in the same cycle.
- irq = |(edge_capture & irq_mask), registered from flops, so no combinational path from the bus. irq stays high until all masked bits are cleared or masked off.
- With edge_rise_en = edge_fall_en = 0 a bit never captures; existing captured bits persist.

Optional Feature:
- Macro: PIO_IN_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever sync_q == filt.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES, filt <= sync_q and the counter clears.
  - filt resets to 0.
  - Glitches shorter than DEBOUNCE_CYCLES produce no edge. Latency grows by DEBOUNCE_CYCLES.
- Undefined: filt = sync_q directly; no counters are instantiated.

Decomposition:
- Package pio_in_pkg:
  - address constants ADDR_DATA=0, ADDR_RISE=1, ADDR_MASK=2, ADDR_CAP=3, ADDR_FALL=4;
  - DATA_W=32;
  - SYNC_MIN=2.
- Sub-module pio_in_bit_filter: synchroniser plus optional debounce counter for one bit, instantiated WIDTH times by generate. Edge detect, registers and the bus stay in the top module.

Test Plan:
- Reset, then read addresses 0-4 -> data=0, rise=0xFF, mask=0, cap=0, fall=0xFF; irq=0.
- in_port bit3 0->1 with mask=0x08 -> cap=0x08 by cycle SYNC_STAGES+1; irq=1 on the following cycle; write 0x08 to address 3 -> cap=0, irq=0.
- fall_en=0x00, toggle bit0 1->0 -> cap stays 0; then 0->1 -> cap=0x01.
- Clear of bit5 issued in the same cycle as a new bit5 event -> cap bit5=1 afterwards.
- Write 0xFFFFFF00 to address 2 with WIDTH=8 -> read back 0x00; assert reset mid-capture -> cap=0 and irq=0 one cycle later.
- With PIO_IN_DEBOUNCE_EN: 10-cycle pulse -> no capture; 20-cycle level change -> capture 16 cycles after sync.
